// File: rtl/soc_io_pkg.sv
// Shared memory-map constants and the UART transmitter state encoding used by the
// SoC I/O peripherals.
package soc_io_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] DATA_OFS        = 32'd0;
   localparam logic [31:0] STATUS_OFS      = 32'd4;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_FULL_BIT = 1;
   localparam int STATUS_OVF_BIT  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Word-granular register decode: the low two byte-address bits are ignored.
   function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
      return addr[31:2] == reg_addr[31:2];
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular FIFO for queued TX bytes; pointers carry one extra wrap bit
// so that full and empty can be told apart when the index bits match.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;

   always_comb begin
      wr_d = wr_q + {{AW{1'b0}}, push};
      rd_d = rd_q + {{AW{1'b0}}, pop};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage carries no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= din;
      end
   end

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA store queues a byte, STATUS load returns
// {overflow, full, busy}. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue.
module uart_tx_mmio
   import soc_io_pkg::*;
#(
   parameter int          CLK_FREQ_HZ = 12_000_000,
   parameter int          BAUD        = 115_200,
   parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] io_rdata,
   output logic        txd,
   output logic        tx_busy
);

   localparam int DIV = CLK_FREQ_HZ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

   tx_state_e   state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        txd_q;
   logic        ovf_q, ovf_d;
   logic [31:0] rdata_q, rdata_d;

   logic        data_hit, status_hit, push_req, push_ok, ovf_set;
   logic        q_full, q_empty, load;
   logic [7:0]  q_head;
   logic [31:0] status_word;

   assign data_hit   = addr_hit(mem_addr, IO_BASE + DATA_OFS);
   assign status_hit = addr_hit(mem_addr, IO_BASE + STATUS_OFS);
   assign push_req   = mem_wmask[0] && data_hit;

   // A byte leaves the queue when the line is idle or the final stop cycle ends.
   assign load    = !q_empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && baud_q == '0));
   assign push_ok = push_req && (!q_full || load);
   assign ovf_set = push_req && q_full && !load;
   assign tx_busy = !q_empty || (state_q != ST_IDLE);

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push_ok),
      .pop    (load),
      .din    (mem_wdata[7:0]),
      .dout   (q_head),
      .full   (q_full),
      .empty  (q_empty)
   );

   logic unused_bits;
   assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0], mem_wmask[3:1]};
`else
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] hold_q, hold_d;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
      if (push_ok) begin
         hold_valid_d = 1'b1;
         hold_d       = mem_wdata[7:0];
      end else if (load) begin
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
      end
   end

   assign q_full  = hold_valid_q;
   assign q_empty = !hold_valid_q;
   assign q_head  = hold_q;

   logic unused_bits;
   assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0], mem_wmask[3:1], 1'(FIFO_DEPTH)};
`endif

   always_comb begin
      status_word                  = '0;
      status_word[STATUS_BUSY_BIT] = tx_busy;
      status_word[STATUS_FULL_BIT] = q_full;
      status_word[STATUS_OVF_BIT]  = ovf_q;

      rdata_d = rdata_q;
      if (mem_rstrb) begin
         rdata_d = status_hit ? status_word : '0;
      end

      // Set wins over the read-to-clear in the same cycle.
      ovf_d = ovf_set || (ovf_q && !(mem_rstrb && status_hit));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  shift_q <= q_head;
                  baud_q  <= DIV_M1;
                  txd_q   <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (baud_q == '0) begin
                  baud_q  <= DIV_M1;
                  bit_q   <= '0;
                  txd_q   <= shift_q[0];
                  state_q <= ST_DATA;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_q == '0) begin
                  baud_q <= DIV_M1;
                  if (bit_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= shift_q >> 1;
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_q == '0) begin
                  if (load) begin
                     shift_q <= q_head;
                     baud_q  <= DIV_M1;
                     txd_q   <= 1'b0;
                     state_q <= ST_START;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end

   assign txd      = txd_q;
   assign io_rdata = rdata_q;

endmodule
